// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus a wide two's-complement negate helper (supports W up to 64).
package muldiv_pkg;

   localparam int NEG_W = 128;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Callers zero-extend into NEG_W bits and truncate the result back.
   function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
      return ~v + NEG_W'(1);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module muldiv_div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   rem_i,
   input  logic [W-1:0] div_i,
   input  logic         bit_i,
   output logic [W:0]   rem_o,
   output logic         q_o
);

   logic [W+1:0] shifted;
   logic [W+1:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {2'b00, div_i};
   assign q_o     = ~diff[W+1];
   assign rem_o   = q_o ? diff[W:0] : shifted[W:0];

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative signed/unsigned multiply and restoring divide with HI/LO results.
// Define MULDIV_FAST_MUL_EN to replace the shift-add loop with a one-cycle product.
module muldiv_iter_unit
   import muldiv_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = $clog2(W) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [1:0]   op_i,
   input  logic [W-1:0] opa_i,
   input  logic [W-1:0] opb_i,
   input  logic         annul_i,
   output logic         busy_o,
   output logic         ready_o,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o,
   output logic         dbz_o
);

   localparam int W2 = 2 * W;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic             dbz_q, dbz_d;

   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic             sa_q, sa_d, sb_q, sb_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [W:0]       rem_q, rem_d;

   logic             is_div, is_signed, neg_a, neg_b, div_zero, accept, last_iter;
   logic [W-1:0]     a_abs, b_abs;
   logic [W:0]       step_rem;
   logic             step_q;
   logic [W2-1:0]    mul_raw, mul_res;
   logic [W-1:0]     quo_raw, quo_res, rem_res;

   assign is_div    = op_i[1];
   assign is_signed = ~op_i[0];
   assign neg_a     = is_signed & opa_i[W-1];
   assign neg_b     = is_signed & opb_i[W-1];
   assign a_abs     = neg_a ? W'(twos_neg(NEG_W'(opa_i))) : opa_i;
   assign b_abs     = neg_b ? W'(twos_neg(NEG_W'(opb_i))) : opb_i;
   assign div_zero  = is_div & (opb_i == '0);
   assign accept    = start_i & ~annul_i & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign last_iter = (cnt_q == CNT_W'(W - 1));

   muldiv_div_step #(.W(W)) u_div_step (
      .rem_i (rem_q),
      .div_i (b_q),
      .bit_i (a_q[W-1]),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

`ifdef MULDIV_FAST_MUL_EN
   assign mul_raw = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
`else
   // Multiplier sits in the low half of acc and is consumed LSB first.
   logic [W:0] mul_sum;
   assign mul_sum = {1'b0, acc_q[W2-1:W]} + {1'b0, (acc_q[0] ? a_q : {W{1'b0}})};
   assign mul_raw = {mul_sum, acc_q[W-1:1]};
`endif

   assign mul_res = (sa_q ^ sb_q) ? W2'(twos_neg(NEG_W'(mul_raw))) : mul_raw;
   assign quo_raw = {a_q[W-2:0], step_q};
   assign quo_res = (sa_q ^ sb_q) ? W'(twos_neg(NEG_W'(quo_raw))) : quo_raw;
   assign rem_res = sa_q ? W'(twos_neg(NEG_W'(step_rem[W-1:0]))) : step_rem[W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      a_d     = a_q;
      b_d     = b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               a_d   = a_abs;
               b_d   = b_abs;
               sa_d  = neg_a;
               sb_d  = neg_b;
               acc_d = {{W{1'b0}}, b_abs};
               rem_d = '0;
               cnt_d = '0;
               if (div_zero) begin
                  state_d = S_DONE;
                  hi_d    = opa_i;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = is_div ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
            state_d = S_DONE;
            hi_d    = mul_res[W2-1:W];
            lo_d    = mul_res[W-1:0];
            dbz_d   = 1'b0;
`else
            acc_d = mul_raw;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
               state_d = S_DONE;
               hi_d    = mul_res[W2-1:W];
               lo_d    = mul_res[W-1:0];
               dbz_d   = 1'b0;
            end
`endif
         end
         S_DIV: begin
            rem_d = step_rem;
            a_d   = quo_raw;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
               state_d = S_DONE;
               hi_d    = rem_res;
               lo_d    = quo_res;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Annul discards the in-flight result; latched HI/LO stay as they were.
      if (annul_i) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dbz_d   = dbz_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   // Operand and working registers are only meaningful after an accept.
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
   end

   assign busy_o  = (state_q == S_MUL) | (state_q == S_DIV);
   assign ready_o = (state_q == S_DONE);
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;
   assign dbz_o   = dbz_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Randomised and directed bench for muldiv_iter_unit against an arithmetic
// reference model of the multiply/divide results and handshake timing.
module tb_muldiv_iter_unit;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_BUSY = 1;
`else
   localparam int MUL_BUSY = W;
`endif
   localparam int LAT_MUL = MUL_BUSY + 1;
   localparam int LAT_DIV = W + 1;

   logic         clk = 1'b0;
   logic         rst, start_i, annul_i;
   logic [1:0]   op_i;
   logic [W-1:0] opa_i, opb_i;
   logic         busy_o, ready_o, dbz_o;
   logic [W-1:0] hi_o, lo_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   muldiv_iter_unit #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .op_i    (op_i),
      .opa_i   (opa_i),
      .opb_i   (opb_i),
      .annul_i (annul_i),
      .busy_o  (busy_o),
      .ready_o (ready_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .dbz_o   (dbz_o)
   );

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Returns {dbz, hi, lo} for one operation using plain integer arithmetic.
   function automatic logic [2*W:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic signed [2*W-1:0] sp;
      logic [2*W-1:0]        p;
      logic [W-1:0]          hi, lo;
      logic                  z;
      z  = 1'b0;
      hi = '0;
      lo = '0;
      case (op)
         2'b00: begin
            sp = $signed(a) * $signed(b);
            p  = sp;
            hi = p[2*W-1:W];
            lo = p[W-1:0];
         end
         2'b01: begin
            p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            hi = p[2*W-1:W];
            lo = p[W-1:0];
         end
         2'b10: begin
            if (b == '0) begin
               z = 1'b1; hi = a; lo = '1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = '0;
            end else begin
               lo = $signed(a) / $signed(b);
               hi = $signed(a) % $signed(b);
            end
         end
         default: begin
            if (b == '0) begin
               z = 1'b1; hi = a; lo = '1;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
      return {z, hi, lo};
   endfunction

   // Reference timing: busy for a fixed number of cycles after accept, then one ready cycle.
   int           m_busy_left = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   logic         m_dbz = 1'b0;
   logic [2*W:0] m_pend = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      end else if (annul_i) begin
         m_busy_left = 0; m_done = 1'b0;
      end else if (m_busy_left > 0) begin
         m_busy_left = m_busy_left - 1;
         m_done = 1'b0;
         if (m_busy_left == 0) begin
            m_done = 1'b1;
            {m_dbz, m_hi, m_lo} = m_pend;
         end
      end else begin
         m_done = 1'b0;
         if (start_i) begin
            m_pend = ref_calc(op_i, opa_i, opb_i);
            if (op_i[1] && opb_i == '0) begin
               m_done = 1'b1;
               {m_dbz, m_hi, m_lo} = m_pend;
            end else begin
               m_busy_left = op_i[1] ? W : MUL_BUSY;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc busy",  65'(busy_o),  65'(m_busy_left > 0));
         check("cyc ready", 65'(ready_o), 65'(m_done));
         check("cyc hi",    65'(hi_o),    65'(m_hi));
         check("cyc lo",    65'(lo_o),    65'(m_lo));
         check("cyc dbz",   65'(dbz_o),   65'(m_dbz));
      end
   end

   task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dbz);
      int n, nb;
      start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
      @(negedge clk);
      start_i = 1'b0;
      n = 1; nb = 0;
      while (!ready_o && n < 200) begin
         if (busy_o) nb++;
         @(negedge clk);
         n++;
      end
      check({name, " latency"}, 65'(n), 65'(exp_lat));
      check({name, " busy cycles"}, 65'(nb), 65'(exp_lat - 1));
      check({name, " hi"}, 65'(hi_o), 65'(exp_hi));
      check({name, " lo"}, 65'(lo_o), 65'(exp_lo));
      check({name, " dbz"}, 65'(dbz_o), 65'(exp_dbz));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return '1;
         3:       return W'($urandom_range(0, 20));
         default: return W'($urandom());
      endcase
   endfunction

   initial begin
      int rdy_cnt;
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
      op_i = 2'b00; opa_i = '0; opb_i = '0;
      repeat (3) @(negedge clk);
      check("reset busy",  65'(busy_o),  65'(0));
      check("reset ready", 65'(ready_o), 65'(0));
      check("reset hi",    65'(hi_o),    65'(0));
      check("reset lo",    65'(lo_o),    65'(0));
      check("reset dbz",   65'(dbz_o),   65'(0));
      chk_en = 1'b1;
      rst = 1'b0;

      check("model multu max", 65'(ref_calc(2'b01, '1, '1)), {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
      check("model mult -7x3", 65'(ref_calc(2'b00, 32'hFFFF_FFF9, 32'd3)), {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
      check("model div -7/2",  65'(ref_calc(2'b10, 32'hFFFF_FFF9, 32'd2)), {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      check("model divu 5/0",  65'(ref_calc(2'b11, 32'd5, 32'd0)), {1'b1, 32'd5, 32'hFFFF_FFFF});

      run_op("multu max", 2'b01, '1, '1, LAT_MUL, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult -7x3", 2'b00, 32'hFFFF_FFF9, 32'd3, LAT_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, LAT_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("divu 100/7", 2'b11, 32'd100, 32'd7, LAT_DIV, 32'd2, 32'd14, 1'b0);
      run_op("div min/-1", 2'b10, 32'h8000_0000, '1, LAT_DIV, 32'd0, 32'h8000_0000, 1'b0);
      run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);
      run_op("mult 2x3", 2'b00, 32'd2, 32'd3, LAT_MUL, 32'd0, 32'd6, 1'b0);

      // Annul at t+10 with an ignored start at t+5.
      start_i = 1'b1; op_i = 2'b10; opa_i = 32'd1000; opb_i = 32'd3;
      @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         start_i = (k == 5);
         op_i    = 2'b01; opa_i = 32'd7; opb_i = 32'd7;
         annul_i = (k == 10);
         @(negedge clk);
      end
      start_i = 1'b0; annul_i = 1'b0;
      check("annul busy", 65'(busy_o), 65'(0));
      rdy_cnt = 0;
      repeat (40) begin
         if (ready_o) rdy_cnt++;
         @(negedge clk);
      end
      check("annul no ready", 65'(rdy_cnt), 65'(0));
      check("annul hi kept", 65'(hi_o), 65'(0));
      check("annul lo kept", 65'(lo_o), 65'(6));

      run_op("b2b first", 2'b01, 32'd2, 32'd2, LAT_MUL, 32'd0, 32'd4, 1'b0);
      run_op("b2b second", 2'b01, 32'd3, 32'd3, LAT_MUL, 32'd0, 32'd9, 1'b0);

      // Reset in the middle of an operation.
      start_i = 1'b1; op_i = 2'b00; opa_i = 32'd11; opb_i = 32'd13;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst busy", 65'(busy_o), 65'(0));
      check("midrst hi",   65'(hi_o),   65'(0));
      check("midrst lo",   65'(lo_o),   65'(0));

      for (int i = 0; i < 4000; i++) begin
         start_i = ($urandom_range(0, 2) == 0);
         annul_i = ($urandom_range(0, 49) == 0);
         rst     = ($urandom_range(0, 999) == 0);
         op_i    = 2'($urandom_range(0, 3));
         opa_i   = pick();
         opb_i   = pick();
         @(negedge clk);
      end
      start_i = 1'b0; annul_i = 1'b0; rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
